// File: rtl/traffic_pkg.sv
// Shared constants and types for the two-way intersection controller:
// light encodings, phase state encoding and a small duration helper.
package traffic_pkg;

    // Light encodings, {red,yellow,green} one-hot
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    // Intersection phases; codes 6 and 7 are illegal and recover to ALL_RED
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        EW_GREEN  = 3'd2,
        EW_YELLOW = 3'd3,
        ALL_RED   = 3'd4,
        PED_WALK  = 3'd5
    } state_e;

    // Largest of the four phase durations; sizes the shared phase timer
    function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: counts cycles spent in the current phase, clears on a
// phase change, can hold its value, and flags the last cycle of a phase whose
// duration is supplied by the controller.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         hold_i,
    input  logic [W-1:0] dur_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over hold, hold wins over increment
    always_comb begin
        count_d = count_q + ONE;
        if (clear_i) begin
            count_d = '0;
        end else if (hold_i) begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Final cycle of a phase lasting dur_i cycles
    assign done_o  = (count_q == (dur_i - ONE));

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer (NS / EW roads plus a pedestrian walk phase).
// Moore FSM: all lamp outputs decode from registered state and the latched
// pedestrian request, so they change on the same edge as the state.
// NS green extends until EW traffic or a pedestrian needs service.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int PED_CYCLES    = 4,
    localparam int TW = $clog2(max_dur(GREEN_CYCLES, YELLOW_CYCLES,
                                       ALLRED_CYCLES, PED_CYCLES)) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ew_car,
    input  logic          ped_req,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          ped_walk,
    output logic          ped_wait,
    output logic [2:0]    dbg_state_o,
    output logic [TW-1:0] dbg_timer_o
);

    state_e        state_q;
    state_e        state_d;
    logic          next_ew_q;
    logic          next_ew_d;
    logic          ped_pending_q;
    logic          ped_pending_d;

    logic [TW-1:0] dur;
    logic [TW-1:0] timer_count;
    logic          timer_done;
    logic          timer_clear;
    logic          timer_hold;

    // Duration of the phase currently being timed
    always_comb begin
        dur = TW'(ALLRED_CYCLES);
        case (state_q)
            NS_GREEN, EW_GREEN:   dur = TW'(GREEN_CYCLES);
            NS_YELLOW, EW_YELLOW: dur = TW'(YELLOW_CYCLES);
            ALL_RED:              dur = TW'(ALLRED_CYCLES);
            PED_WALK:             dur = TW'(PED_CYCLES);
            default:              dur = TW'(ALLRED_CYCLES);
        endcase
    end

    // Timer restarts on every phase change; saturates while NS green is held
    assign timer_clear = (state_d != state_q);
    assign timer_hold  = (state_q == NS_GREEN) && timer_done && !(ew_car || ped_pending_q);

    phase_timer #(
        .W (TW)
    ) u_timer (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (timer_clear),
        .hold_i  (timer_hold),
        .dur_i   (dur),
        .count_o (timer_count),
        .done_o  (timer_done)
    );

    // State, road-turn and pedestrian-latch registers; reset drops any request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= NS_GREEN;
            next_ew_q     <= 1'b1;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_ew_q     <= next_ew_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Phase sequencing; next_ew records which road gets green after the clearance
    always_comb begin
        state_d   = state_q;
        next_ew_d = next_ew_q;
        case (state_q)
            NS_GREEN: begin
                if (timer_done && (ew_car || ped_pending_q)) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer_done) begin
                    state_d   = ALL_RED;
                    next_ew_d = 1'b1;
                end
            end
            EW_GREEN: begin
                if (timer_done) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer_done) begin
                    state_d   = ALL_RED;
                    next_ew_d = 1'b0;
                end
            end
            ALL_RED: begin
                if (timer_done) begin
                    if (ped_pending_q) begin
                        state_d = PED_WALK;
                    end else if (next_ew_q) begin
                        state_d = EW_GREEN;
                    end else begin
                        state_d = NS_GREEN;
                    end
                end
            end
            PED_WALK: begin
                if (timer_done) begin
                    if (next_ew_q) begin
                        state_d = EW_GREEN;
                    end else begin
                        state_d = NS_GREEN;
                    end
                end
            end
            default: begin
                state_d   = ALL_RED;
                next_ew_d = 1'b0;
            end
        endcase
    end

    // Pedestrian latch: requests ignored during the walk; a new press beats the clear on walk entry
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q != PED_WALK) begin
            if (ped_req) begin
                ped_pending_d = 1'b1;
            end else if (state_d == PED_WALK) begin
                ped_pending_d = 1'b0;
            end
        end
    end

    // Lamp decode from registered state only; unknown codes show all red
    always_comb begin
        ns_light = L_RED;
        ew_light = L_RED;
        ped_walk = 1'b0;
        case (state_q)
            NS_GREEN:  ns_light = L_GRN;
            NS_YELLOW: ns_light = L_YEL;
            EW_GREEN:  ew_light = L_GRN;
            EW_YELLOW: ew_light = L_YEL;
            PED_WALK:  ped_walk = 1'b1;
            default: begin
                ns_light = L_RED;
                ew_light = L_RED;
            end
        endcase
        ped_wait    = ped_pending_q;
        dbg_state_o = state_q;
        dbg_timer_o = timer_count;
    end

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: table-driven directed scenarios followed
// by a long random run against a cycle model with safety and dwell checks.
module tb_intersection_controller;
    import traffic_pkg::*;

    localparam int G = 8;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int P = 4;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic       ped_wait;
    logic [2:0] dbg_state;
    logic [3:0] dbg_timer;

    always #5 clock = ~clock;

    intersection_controller #(
        .GREEN_CYCLES  (G),
        .YELLOW_CYCLES (Y),
        .ALLRED_CYCLES (A),
        .PED_CYCLES    (P)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .ped_walk    (ped_walk),
        .ped_wait    (ped_wait),
        .dbg_state_o (dbg_state),
        .dbg_timer_o (dbg_timer)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- vector table ----------------
    typedef struct {
        int         scn;
        logic       rst;
        logic       ew;
        logic       ped;
        logic [7:0] exp;   // {ns, ew, walk, wait}
        logic       chk;
    } vec_t;

    vec_t vecs[$];
    int   cur_scn;

    task automatic add(input int n, input logic r, input logic e, input logic p,
                       input logic [2:0] ns, input logic [2:0] ew,
                       input logic w, input logic wt, input logic c);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.scn = cur_scn;
            v.rst = r;
            v.ew  = e;
            v.ped = p;
            v.exp = {ns, ew, w, wt};
            v.chk = c;
            vecs.push_back(v);
        end
    endtask

    task automatic add_reset();
        add(1, 1'b1, 1'b0, 1'b0, L_RED, L_RED, 1'b0, 1'b0, 1'b0);
    endtask

    // Full ew_car=1 cycle: NS_G 0-7, NS_Y 8-9, AR 10, EW_G 11-18, EW_Y 19-20, AR 21, NS_G 22
    task automatic add_scn1_body();
        add(G, 0, 1, 0, L_GRN, L_RED, 0, 0, 1);
        add(Y, 0, 1, 0, L_YEL, L_RED, 0, 0, 1);
        add(A, 0, 1, 0, L_RED, L_RED, 0, 0, 1);
        add(G, 0, 1, 0, L_RED, L_GRN, 0, 0, 1);
        add(Y, 0, 1, 0, L_RED, L_YEL, 0, 0, 1);
        add(A, 0, 1, 0, L_RED, L_RED, 0, 0, 1);
        add(1, 0, 1, 0, L_GRN, L_RED, 0, 0, 1);
    endtask

    // ped pulse at 3 with no EW traffic, up to and including ALL_RED at 10
    task automatic add_ped_prefix();
        add(3, 0, 0, 0, L_GRN, L_RED, 0, 0, 1);
        add(1, 0, 0, 1, L_GRN, L_RED, 0, 0, 1);
        add(4, 0, 0, 0, L_GRN, L_RED, 0, 1, 1);
        add(Y, 0, 0, 0, L_YEL, L_RED, 0, 1, 1);
        add(A, 0, 0, 0, L_RED, L_RED, 0, 1, 1);
    endtask

    task automatic build_table();
        // 1: steady EW demand
        cur_scn = 1;
        add_reset();
        add_scn1_body();
        // 2: NS green held for 50 cycles, then EW demand exits on the next edge
        cur_scn = 2;
        add_reset();
        add(50, 0, 0, 0, L_GRN, L_RED, 0, 0, 1);
        add(1,  0, 1, 0, L_GRN, L_RED, 0, 0, 1);
        add(Y,  0, 1, 0, L_YEL, L_RED, 0, 0, 1);
        add(A,  0, 1, 0, L_RED, L_RED, 0, 0, 1);
        // 3: single pedestrian pulse served, then EW green
        cur_scn = 3;
        add_reset();
        add_ped_prefix();
        add(P, 0, 0, 0, L_RED, L_RED, 1, 0, 1);
        add(1, 0, 0, 0, L_RED, L_GRN, 0, 0, 1);
        // 4: button held through the walk; re-latched only after it, served at next ALL_RED
        cur_scn = 4;
        add_reset();
        add_ped_prefix();
        add(P, 0, 0, 1, L_RED, L_RED, 1, 0, 1);   // 11-14
        add(1, 0, 0, 1, L_RED, L_GRN, 0, 0, 1);   // 15
        add(4, 0, 0, 1, L_RED, L_GRN, 0, 1, 1);   // 16-19
        add(3, 0, 0, 0, L_RED, L_GRN, 0, 1, 1);   // 20-22
        add(Y, 0, 0, 0, L_RED, L_YEL, 0, 1, 1);   // 23-24
        add(A, 0, 0, 0, L_RED, L_RED, 0, 1, 1);   // 25
        add(P, 0, 0, 0, L_RED, L_RED, 1, 0, 1);   // 26-29
        add(1, 0, 0, 0, L_GRN, L_RED, 0, 0, 1);   // 30, NS turn after EW
        // 5: reset during EW green discards a pending request and restarts timing
        cur_scn = 5;
        add_reset();
        add(G, 0, 1, 0, L_GRN, L_RED, 0, 0, 1);
        add(Y, 0, 1, 0, L_YEL, L_RED, 0, 0, 1);
        add(A, 0, 1, 0, L_RED, L_RED, 0, 0, 1);
        add(1, 0, 1, 0, L_RED, L_GRN, 0, 0, 1);   // 11
        add(1, 0, 1, 1, L_RED, L_GRN, 0, 0, 1);   // 12
        add(1, 1, 1, 0, L_RED, L_GRN, 0, 1, 1);   // 13, reset asserted
        add_scn1_body();
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check8(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got {ns,ew,walk,wait}=%b, expected %b", name, idx, got, exp);
        end
    endtask

    function automatic int dur_of(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return G;
            NS_YELLOW, EW_YELLOW: return Y;
            PED_WALK:             return P;
            default:              return A;
        endcase
    endfunction

    function automatic logic [7:0] model_out(input state_e s, input logic pend);
        case (s)
            NS_GREEN:  return {L_GRN, L_RED, 1'b0, pend};
            NS_YELLOW: return {L_YEL, L_RED, 1'b0, pend};
            EW_GREEN:  return {L_RED, L_GRN, 1'b0, pend};
            EW_YELLOW: return {L_RED, L_YEL, 1'b0, pend};
            PED_WALK:  return {L_RED, L_RED, 1'b1, pend};
            default:   return {L_RED, L_RED, 1'b0, pend};
        endcase
    endfunction

    function automatic state_e phase_of(input logic [2:0] ns, input logic [2:0] ew, input logic w);
        if (w)            return PED_WALK;
        if (ns == L_GRN)  return NS_GREEN;
        if (ns == L_YEL)  return NS_YELLOW;
        if (ew == L_GRN)  return EW_GREEN;
        if (ew == L_YEL)  return EW_YELLOW;
        return ALL_RED;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    state_e     m_st, m_nst, ph, prev_ph;
    int         m_t, m_nt, run;
    logic       m_nx, m_nnx, m_ped, m_nped, m_done;
    logic [7:0] got;

    initial begin
        build_table();

        // Directed table: inputs for a period, outputs observed in that period
        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            ew_car  = vecs[i].ew;
            ped_req = vecs[i].ped;
            if (vecs[i].chk) begin
                got = {ns_light, ew_light, ped_walk, ped_wait};
                check8($sformatf("scn%0d", vecs[i].scn), i, got, vecs[i].exp);
            end
            @(posedge clock);
            #1;
        end

        // Random traffic against a cycle model
        reset   = 1'b1;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_st  = NS_GREEN;
        m_t   = 0;
        m_nx  = 1'b1;
        m_ped = 1'b0;
        prev_ph = NS_GREEN;
        run     = 0;

        for (int c = 0; c < 10000; c++) begin
            ew_car  = ($urandom_range(0, 3) == 0);
            ped_req = ($urandom_range(0, 24) == 0);

            got = {ns_light, ew_light, ped_walk, ped_wait};
            check8("rand", c, got, model_out(m_st, m_ped));

            n_tests++;
            if ((ns_light != L_RED && ew_light != L_RED) ||
                (ped_walk && (ns_light != L_RED || ew_light != L_RED))) begin
                n_fail++;
                $display("FAIL safety[%0d]: got ns=%b ew=%b walk=%b, required no conflicting lamps",
                         c, ns_light, ew_light, ped_walk);
            end

            ph = phase_of(ns_light, ew_light, ped_walk);
            if (c == 0 || ph == prev_ph) begin
                run++;
            end else begin
                n_tests++;
                if ((prev_ph == NS_GREEN) ? (run < G) : (run != dur_of(prev_ph))) begin
                    n_fail++;
                    $display("FAIL dwell[%0d]: phase %0d lasted %0d cycles, required %s%0d",
                             c, prev_ph, run, (prev_ph == NS_GREEN) ? ">=" : "", dur_of(prev_ph));
                end
                run = 1;
            end
            prev_ph = ph;

            // model step for this edge
            m_done = (m_t == dur_of(m_st) - 1);
            m_nst  = m_st;
            m_nnx  = m_nx;
            case (m_st)
                NS_GREEN:  if (m_done && (ew_car || m_ped)) m_nst = NS_YELLOW;
                NS_YELLOW: if (m_done) begin m_nst = ALL_RED; m_nnx = 1'b1; end
                EW_GREEN:  if (m_done) m_nst = EW_YELLOW;
                EW_YELLOW: if (m_done) begin m_nst = ALL_RED; m_nnx = 1'b0; end
                ALL_RED:   if (m_done) m_nst = m_ped ? PED_WALK : (m_nx ? EW_GREEN : NS_GREEN);
                default:   if (m_done) m_nst = m_nx ? EW_GREEN : NS_GREEN;
            endcase
            m_nped = m_ped;
            if (m_st != PED_WALK && ped_req)      m_nped = 1'b1;
            else if (m_st != PED_WALK && m_nst == PED_WALK) m_nped = 1'b0;
            if (m_nst != m_st)  m_nt = 0;
            else if (m_done)    m_nt = m_t;
            else                m_nt = m_t + 1;

            @(posedge clock);
            #1;
            m_st  = m_nst;
            m_nx  = m_nnx;
            m_ped = m_nped;
            m_t   = m_nt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
